// File: rtl/sprite_cmd_pkg.sv
// Shared types and constants for the sprite command issuer.
// Latency: n/a (types only).
// Backpressure: n/a.
package sprite_cmd_pkg;

  localparam int SPR_IMG_ID_W = 3;
  localparam int SPR_COORD_W  = 10;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam logic [SPR_IMG_ID_W-1:0] IMG_MAIN_CHARACTER = 3'd0;
  localparam logic [SPR_IMG_ID_W-1:0] IMG_TILE           = 3'd1;

  typedef struct packed {
    logic                    valid;
    logic [SPR_IMG_ID_W-1:0] img_id;
    logic [SPR_COORD_W-1:0]  x;
    logic [SPR_COORD_W-1:0]  y;
  } sprite_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_ISSUE,
    ST_RELEASE,
    ST_FINISH
  } state_t;

  function automatic logic on_screen(input logic [SPR_COORD_W-1:0] x,
                                     input logic [SPR_COORD_W-1:0] y);
    return (int'(x) < SCREEN_W) && (int'(y) < SCREEN_H);
  endfunction

endpackage

// File: rtl/sprite_cmd_issuer_if.sv
// Start/Done draw-command link between issuer (master) and accelerator (slave).
// Latency: combinational wires only.
// Backpressure: four-phase; Done held high until Start falls.
interface sprite_cmd_issuer_if #(
  parameter int IMG_ID_W = 3,
  parameter int COORD_W  = 10
) ();
  logic                Start;
  logic                Done;
  logic [IMG_ID_W-1:0] img_id;
  logic [COORD_W-1:0]  imgX;
  logic [COORD_W-1:0]  imgY;

  modport master (output Start, img_id, imgX, imgY, input Done);
  modport slave  (input Start, img_id, imgX, imgY, output Done);
endinterface

// File: rtl/sprite_cmd_issuer_table.sv
// Sprite entry register file: one synchronous write port, one combinational read port.
// Latency: write visible the cycle after tbl_we; read is same-cycle (old value on collision).
// Backpressure: none, writes always accepted.
module sprite_table
  import sprite_cmd_pkg::*;
#(
  parameter int  NUM_SPRITES = 16,
  localparam int IDX_W       = $clog2(NUM_SPRITES)
) (
  input  logic          frame_clk,
  input  logic          Reset,
  input  logic          we,
  input  logic [IDX_W-1:0] waddr,
  input  sprite_entry_t wdata,
  input  logic [IDX_W-1:0] raddr,
  output sprite_entry_t rdata
);

  sprite_entry_t mem [NUM_SPRITES];

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sprite_cmd_issuer.sv
// Walks the sprite table on frame_start and issues one Start/Done command per valid entry.
// Latency: first Start 2 cycles after frame_start; 1 cycle per skipped entry. Build option: SPRITE_CULL_EN.
// Backpressure: each command waits for Done high, then Done low, before the next is issued.
module sprite_cmd_issuer
  import sprite_cmd_pkg::*;
#(
  parameter int  NUM_SPRITES = 16,
  parameter int  IMG_ID_W    = SPR_IMG_ID_W,
  parameter int  COORD_W     = SPR_COORD_W,
  localparam int IDX_W       = $clog2(NUM_SPRITES),
  localparam int CNT_W       = IDX_W + 1
) (
  input  logic                 frame_clk,
  input  logic                 Reset,
  input  logic                 frame_start,
  input  logic                 tbl_we,
  input  logic [IDX_W-1:0]     tbl_addr,
  input  logic                 tbl_valid,
  input  logic [IMG_ID_W-1:0]  tbl_img_id,
  input  logic [COORD_W-1:0]   tbl_x,
  input  logic [COORD_W-1:0]   tbl_y,
  sprite_cmd_issuer_if.master  acc,
  output logic                 busy,
  output logic                 overrun,
  output logic [CNT_W-1:0]     drawn_count
);

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    idx, idx_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                start_q, start_nxt;
  logic [IMG_ID_W-1:0] id_q, id_nxt;
  logic [COORD_W-1:0]  x_q, x_nxt, y_q, y_nxt;
  logic                busy_q, busy_nxt;
  logic                overrun_q, overrun_nxt;
  logic [CNT_W-1:0]    drawn_q, drawn_nxt;

  sprite_entry_t wr_entry, rd_entry;
  logic          issue_ok;
  logic          last;

  assign wr_entry = '{valid: tbl_valid, img_id: tbl_img_id, x: tbl_x, y: tbl_y};

  sprite_table #(.NUM_SPRITES(NUM_SPRITES)) u_table (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .we        (tbl_we),
    .waddr     (tbl_addr),
    .wdata     (wr_entry),
    .raddr     (idx),
    .rdata     (rd_entry)
  );

`ifdef SPRITE_CULL_EN
  assign issue_ok = rd_entry.valid && on_screen(rd_entry.x, rd_entry.y);
`else
  assign issue_ok = rd_entry.valid;
`endif

  assign last = (idx == IDX_W'(NUM_SPRITES - 1));

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    cnt_nxt     = cnt;
    start_nxt   = start_q;
    id_nxt      = id_q;
    x_nxt       = x_q;
    y_nxt       = y_q;
    busy_nxt    = busy_q;
    drawn_nxt   = drawn_q;
    // A pass in progress (FINISH included) is never restarted; just flag it.
    overrun_nxt = overrun_q | (frame_start && (state != ST_IDLE));

    case (state)
      ST_IDLE: begin
        if (frame_start) begin
          idx_nxt   = '0;
          cnt_nxt   = '0;
          busy_nxt  = 1'b1;
          state_nxt = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (issue_ok) begin
          id_nxt    = rd_entry.img_id;
          x_nxt     = rd_entry.x;
          y_nxt     = rd_entry.y;
          start_nxt = 1'b1;
          state_nxt = ST_ISSUE;
        end else if (last) begin
          state_nxt = ST_FINISH;
        end else begin
          idx_nxt = idx + IDX_W'(1);
        end
      end
      ST_ISSUE: begin
        if (acc.Done) begin
          start_nxt = 1'b0;
          cnt_nxt   = cnt + CNT_W'(1);
          state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!acc.Done) begin
          if (last) begin
            state_nxt = ST_FINISH;
          end else begin
            idx_nxt   = idx + IDX_W'(1);
            state_nxt = ST_SCAN;
          end
        end
      end
      ST_FINISH: begin
        drawn_nxt = cnt;
        busy_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state     <= ST_IDLE;
      idx       <= '0;
      cnt       <= '0;
      start_q   <= 1'b0;
      id_q      <= '0;
      x_q       <= '0;
      y_q       <= '0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      drawn_q   <= '0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      cnt       <= cnt_nxt;
      start_q   <= start_nxt;
      id_q      <= id_nxt;
      x_q       <= x_nxt;
      y_q       <= y_nxt;
      busy_q    <= busy_nxt;
      overrun_q <= overrun_nxt;
      drawn_q   <= drawn_nxt;
    end
  end

  assign acc.Start   = start_q;
  assign acc.img_id  = id_q;
  assign acc.imgX    = x_q;
  assign acc.imgY    = y_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;
  assign drawn_count = drawn_q;

endmodule

// File: tb/tb_sprite_cmd_issuer.sv
// Directed bench for sprite_cmd_issuer: vector table pass plus handshake corner sequences.
module tb_sprite_cmd_issuer;
  import sprite_cmd_pkg::*;

  logic       frame_clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_start = 1'b0;
  logic       tbl_we = 1'b0;
  logic [3:0] tbl_addr = '0;
  logic       tbl_valid = 1'b0;
  logic [2:0] tbl_img_id = '0;
  logic [9:0] tbl_x = '0;
  logic [9:0] tbl_y = '0;
  logic       busy;
  logic       overrun;
  logic [4:0] drawn_count;
  logic       done_r = 1'b0;

  sprite_cmd_issuer_if acc ();
  assign acc.Done = done_r;

  sprite_cmd_issuer dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .frame_start (frame_start),
    .tbl_we      (tbl_we),
    .tbl_addr    (tbl_addr),
    .tbl_valid   (tbl_valid),
    .tbl_img_id  (tbl_img_id),
    .tbl_x       (tbl_x),
    .tbl_y       (tbl_y),
    .acc         (acc),
    .busy        (busy),
    .overrun     (overrun),
    .drawn_count (drawn_count)
  );

  always #5 frame_clk = ~frame_clk;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [2:0] id;
    logic [9:0] x;
    logic [9:0] y;
  } cmd_t;
  cmd_t log_q[$];
  cmd_t cur;
  logic start_d = 1'b0;
  int   stable_err = 0;
  int   dly = 0;

  // Accelerator model: Done rises a few cycles after Start, drops once Start is seen low.
  always @(negedge frame_clk) begin
    if (acc.Start) begin
      if (!done_r) begin
        if (dly == 2) done_r = 1'b1;
        else dly = dly + 1;
      end
    end else begin
      dly    = 0;
      done_r = 1'b0;
    end
  end

  // Command logger plus output-stability / no-early-restart monitor.
  always @(negedge frame_clk) begin
    if (acc.Start && !start_d) begin
      if (done_r) stable_err = stable_err + 1;
      cur = '{acc.img_id, acc.imgX, acc.imgY};
      log_q.push_back(cur);
    end else if (acc.Start && (acc.img_id != cur.id || acc.imgX != cur.x || acc.imgY != cur.y)) begin
      stable_err = stable_err + 1;
    end
    start_d = acc.Start;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d", nm, act, exp);
  endtask

  task automatic wr(input int a, input int v, input int id, input int x, input int y);
    @(negedge frame_clk);
    tbl_we     = 1'b1;
    tbl_addr   = 4'(a);
    tbl_valid  = 1'(v);
    tbl_img_id = 3'(id);
    tbl_x      = 10'(x);
    tbl_y      = 10'(y);
    @(negedge frame_clk);
    tbl_we = 1'b0;
  endtask

  task automatic pulse();
    @(negedge frame_clk);
    frame_start = 1'b1;
    @(negedge frame_clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (busy && k < 2000) begin
      @(negedge frame_clk);
      k++;
    end
    chk(nm, int'(busy), 0);
  endtask

  task automatic wait_start(input logic val, input string nm);
    int k = 0;
    while (acc.Start !== val && k < 200) begin
      @(negedge frame_clk);
      k++;
    end
    chk(nm, int'(acc.Start), int'(val));
  endtask

  typedef struct {
    int addr;
    int v;
    int id;
    int x;
    int y;
    int exp_issue;
  } vec_t;
  vec_t vt[5];

  initial begin
    int exp_cnt;
    int k;
    int nb;
    bit cull;
`ifdef SPRITE_CULL_EN
    cull = 1'b1;
`else
    cull = 1'b0;
`endif
    vt[0] = '{0,  1, int'(IMG_MAIN_CHARACTER), 100, 50,  1};
    vt[1] = '{3,  1, int'(IMG_TILE),           320, 240, 1};
    vt[2] = '{5,  0, 2,                        10,  10,  0};
    vt[3] = '{9,  1, 2,                        700, 20,  cull ? 0 : 1};
    vt[4] = '{15, 1, 1,                        639, 479, 1};

    repeat (3) @(negedge frame_clk);
    Reset = 1'b0;
    @(negedge frame_clk);
    chk("rst_start",   int'(acc.Start),  0);
    chk("rst_img_id",  int'(acc.img_id), 0);
    chk("rst_imgX",    int'(acc.imgX),   0);
    chk("rst_imgY",    int'(acc.imgY),   0);
    chk("rst_busy",    int'(busy),       0);
    chk("rst_overrun", int'(overrun),    0);
    chk("rst_drawn",   int'(drawn_count), 0);

    // Table-driven pass, including entry 15 (last index) and an off-screen entry.
    for (int i = 0; i < 5; i++) wr(vt[i].addr, vt[i].v, vt[i].id, vt[i].x, vt[i].y);
    log_q.delete();
    pulse();
    chk("busy_after_start", int'(busy), 1);
    chk("start_not_yet", int'(acc.Start), 0);
    @(negedge frame_clk);
    chk("start_latency2", int'(acc.Start), 1);
    wait_idle("pass1_timeout");
    exp_cnt = 0;
    for (int i = 0; i < 5; i++) exp_cnt += vt[i].exp_issue;
    chk("pass1_ncmds", log_q.size(), exp_cnt);
    k = 0;
    for (int i = 0; i < 5; i++) begin
      if (vt[i].exp_issue != 0) begin
        if (k < log_q.size()) begin
          chk($sformatf("pass1_id[%0d]", i), int'(log_q[k].id), vt[i].id);
          chk($sformatf("pass1_x[%0d]", i),  int'(log_q[k].x),  vt[i].x);
          chk($sformatf("pass1_y[%0d]", i),  int'(log_q[k].y),  vt[i].y);
        end
        k++;
      end
    end
    chk("pass1_drawn", int'(drawn_count), exp_cnt);
    chk("pass1_overrun", int'(overrun), 0);

    // Empty table: busy for NUM_SPRITES+1 cycles, drawn_count returns to 0.
    for (int i = 0; i < 5; i++) wr(vt[i].addr, 0, 0, 0, 0);
    log_q.delete();
    @(negedge frame_clk);
    frame_start = 1'b1;
    @(negedge frame_clk);
    frame_start = 1'b0;
    nb = 0;
    while (busy && nb < 100) begin
      nb++;
      @(negedge frame_clk);
    end
    chk("empty_busy_cycles", nb, 17);
    chk("empty_ncmds", log_q.size(), 0);
    chk("empty_drawn", int'(drawn_count), 0);

    // frame_start landing in the FINISH cycle is ignored but flags overrun.
    pulse();
    repeat (16) @(negedge frame_clk);
    chk("finish_busy", int'(busy), 1);
    frame_start = 1'b1;
    @(negedge frame_clk);
    frame_start = 1'b0;
    chk("finish_fs_busy", int'(busy), 0);
    chk("finish_fs_overrun", int'(overrun), 1);
    @(negedge frame_clk);
    chk("finish_fs_no_restart", int'(busy), 0);
    Reset = 1'b1;
    @(negedge frame_clk);
    Reset = 1'b0;
    chk("overrun_cleared", int'(overrun), 0);

    // Snapshot: rewriting entry 0 during ISSUE does not alter the in-flight command.
    wr(0, 1, int'(IMG_MAIN_CHARACTER), 100, 50);
    log_q.delete();
    pulse();
    wait_start(1'b1, "snap_start_hi");
    wr(0, 1, int'(IMG_MAIN_CHARACTER), 200, 50);
    chk("snap_imgX_held", int'(acc.imgX), 100);
    wait_start(1'b0, "snap_start_lo");
    wait_idle("snap_timeout");
    chk("snap_ncmds", log_q.size(), 1);
    if (log_q.size() > 0) chk("snap_x_old", int'(log_q[0].x), 100);
    pulse();
    wait_idle("snap2_timeout");
    chk("snap2_ncmds", log_q.size(), 2);
    if (log_q.size() > 1) chk("snap2_x_new", int'(log_q[1].x), 200);

    // Overrun while busy: pass completes normally, flag sticks.
    wr(3, 1, int'(IMG_TILE), 320, 240);
    log_q.delete();
    pulse();
    repeat (3) @(negedge frame_clk);
    pulse();
    chk("ovr_set", int'(overrun), 1);
    wait_idle("ovr_timeout");
    chk("ovr_drawn", int'(drawn_count), 2);
    chk("ovr_ncmds", log_q.size(), 2);
    if (log_q.size() > 1) chk("ovr_second_x", int'(log_q[1].x), 320);
    pulse();
    wait_idle("ovr2_timeout");
    chk("ovr_sticky", int'(overrun), 1);

    // Reset mid-handshake.
    pulse();
    wait_start(1'b1, "rstmid_start_hi");
    Reset = 1'b1;
    @(negedge frame_clk);
    chk("rstmid_start", int'(acc.Start), 0);
    chk("rstmid_busy", int'(busy), 0);
    chk("rstmid_drawn", int'(drawn_count), 0);
    chk("rstmid_overrun", int'(overrun), 0);
    Reset = 1'b0;
    repeat (2) @(negedge frame_clk);
    log_q.delete();
    pulse();
    wait_idle("rstmid_timeout");
    chk("rstmid_table_cleared", log_q.size(), 0);
    chk("rstmid_drawn_after", int'(drawn_count), 0);

    chk("handshake_stability", stable_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
